// File: rtl/prog_mealy_fsm_if.sv
// prog_mealy_fsm_if: run/config/status bundle for the programmable table-driven FSM
//   master drives en, x, cfg_we, cfg_state, cfg_in, cfg_next, cfg_out
//   slave  drives y, state_o, trans_cnt
interface prog_mealy_fsm_if #(
  parameter int STATE_W = 2,
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1
);
  logic               en;
  logic [IN_W-1:0]    x;
  logic [OUT_W-1:0]   y;
  logic [STATE_W-1:0] state_o;
  logic               cfg_we;
  logic [STATE_W-1:0] cfg_state;
  logic [IN_W-1:0]    cfg_in;
  logic [STATE_W-1:0] cfg_next;
  logic [OUT_W-1:0]   cfg_out;
  logic [15:0]        trans_cnt;
  modport master (
    output en, x, cfg_we, cfg_state, cfg_in, cfg_next, cfg_out,
    input  y, state_o, trans_cnt
  );
  modport slave (
    input  en, x, cfg_we, cfg_state, cfg_in, cfg_next, cfg_out,
    output y, state_o, trans_cnt
  );
endinterface

// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm: run-time programmable table-driven FSM, Mealy or registered output
//   clk, rst_n : clock and synchronous active-low reset
//   bus.slave  : en/x advance the machine, cfg_* write one table entry per cycle,
//                y/state_o/trans_cnt report output, current state and state-change count
module prog_mealy_fsm #(
  parameter int STATE_W     = 2,
  parameter int IN_W        = 2,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0,
  parameter int REG_OUT     = 0
) (
  input logic              clk,
  input logic              rst_n,
  prog_mealy_fsm_if.slave  bus
);
  localparam int N_ENT = 2 ** (STATE_W + IN_W);
  typedef struct packed {
    logic [STATE_W-1:0] nxt;
    logic [OUT_W-1:0]   out;
  } entry_t;
  entry_t             tbl [N_ENT];
  entry_t             cur;
  logic [STATE_W-1:0] state;
  logic [OUT_W-1:0]   y_q;
  logic [15:0]        cnt;
  // Reads see the table as it stood before this cycle's write, so a
  // same-cycle write to {state, x} only takes effect next cycle.
  assign cur = tbl[{state, bus.x}];
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < N_ENT; i++) tbl[i] <= '{nxt: STATE_W'(RESET_STATE), out: '0};
    else if (bus.cfg_we)
      tbl[{bus.cfg_state, bus.cfg_in}] <= '{nxt: bus.cfg_next, out: bus.cfg_out};
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= STATE_W'(RESET_STATE);
      cnt   <= '0;
      y_q   <= '0;
    end else if (bus.en) begin
      state <= cur.nxt;
      y_q   <= cur.out;
      if (cur.nxt != state && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  assign bus.y         = (REG_OUT != 0) ? y_q : cur.out;
  assign bus.state_o   = state;
  assign bus.trans_cnt = cnt;
endmodule

// File: tb/tb_prog_mealy_fsm.sv
// tb_prog_mealy_fsm: directed bench for Mealy and registered-output variants side by side
module tb_prog_mealy_fsm;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       en = 0;
  logic [1:0] x = 0;
  logic       cfg_we = 0;
  logic [1:0] cfg_state = 0;
  logic [1:0] cfg_in = 0;
  logic [1:0] cfg_next = 0;
  logic       cfg_out = 0;
  int         total = 0;
  int         bad = 0;
  logic [1:0] t4_nxt [16];
  logic       t4_out [16];
  logic [1:0] xs [4];
  logic [1:0] exp_st [4];
  logic       exp_y [4];
  always #5 clk = ~clk;
  prog_mealy_fsm_if #(.STATE_W(2), .IN_W(2), .OUT_W(1)) b0 ();
  prog_mealy_fsm_if #(.STATE_W(2), .IN_W(2), .OUT_W(1)) b1 ();
  assign b0.en = en;         assign b1.en = en;
  assign b0.x = x;           assign b1.x = x;
  assign b0.cfg_we = cfg_we; assign b1.cfg_we = cfg_we;
  assign b0.cfg_state = cfg_state; assign b1.cfg_state = cfg_state;
  assign b0.cfg_in = cfg_in;       assign b1.cfg_in = cfg_in;
  assign b0.cfg_next = cfg_next;   assign b1.cfg_next = cfg_next;
  assign b0.cfg_out = cfg_out;     assign b1.cfg_out = cfg_out;
  prog_mealy_fsm #(.STATE_W(2), .IN_W(2), .OUT_W(1), .RESET_STATE(0), .REG_OUT(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  prog_mealy_fsm #(.STATE_W(2), .IN_W(2), .OUT_W(1), .RESET_STATE(0), .REG_OUT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] s, input logic [1:0] i, input logic [1:0] n, input logic o);
    cfg_we = 1; cfg_state = s; cfg_in = i; cfg_next = n; cfg_out = o;
    tick();
    cfg_we = 0;
  endtask
  task automatic chk_both_st(input string tag, input logic [1:0] st, input logic [15:0] c);
    chk({tag, "_st_m"}, 32'(b0.state_o), 32'(st));
    chk({tag, "_st_r"}, 32'(b1.state_o), 32'(st));
    chk({tag, "_cnt_m"}, 32'(b0.trans_cnt), 32'(c));
    chk({tag, "_cnt_r"}, 32'(b1.trans_cnt), 32'(c));
  endtask
  initial begin
    t4_nxt = '{2'd0, 2'd1, 2'd2, 2'd0,  2'd2, 2'd0, 2'd3, 2'd1,
               2'd3, 2'd0, 2'd1, 2'd2,  2'd1, 2'd0, 2'd3, 2'd0};
    t4_out = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0};
    xs     = '{2'b01, 2'b10, 2'b00, 2'b00};
    exp_st = '{2'd1, 2'd3, 2'd1, 2'd2};
    exp_y  = '{1'b0, 1'b0, 1'b1, 1'b0};
    repeat (2) tick();
    rst_n = 1;
    chk_both_st("reset", 2'd0, 16'd0);
    chk("reset_y_m", 32'(b0.y), 32'd0);
    chk("reset_y_r", 32'(b1.y), 32'd0);
    en = 1; x = 2'b01;
    repeat (3) tick();
    chk_both_st("noload", 2'd0, 16'd0);
    chk("noload_y_m", 32'(b0.y), 32'd0);
    chk("noload_y_r", 32'(b1.y), 32'd0);
    en = 0;
    for (int i = 0; i < 16; i++) wr(2'(i >> 2), 2'(i), t4_nxt[i], t4_out[i]);
    en = 1;
    for (int k = 0; k < 4; k++) begin
      x = xs[k];
      #1;
      chk($sformatf("run%0d_y_m", k), 32'(b0.y), 32'(exp_y[k]));
      tick();
      chk($sformatf("run%0d_st", k), 32'(b0.state_o), 32'(exp_st[k]));
      chk($sformatf("run%0d_y_r", k), 32'(b1.y), 32'(exp_y[k]));
    end
    chk_both_st("run_end", 2'd2, 16'd4);
    x = 2'b00; cfg_we = 1; cfg_state = 2'd2; cfg_in = 2'b00; cfg_next = 2'd0; cfg_out = 0;
    #1;
    chk("same_pre_y_m", 32'(b0.y), 32'd1);
    tick();
    cfg_we = 0; en = 0;
    chk_both_st("same_wr", 2'd3, 16'd5);
    chk("same_wr_y_r", 32'(b1.y), 32'd1);
    x = 2'b01;
    tick();
    chk("hold_y_r_a", 32'(b1.y), 32'd1);
    chk("hold_y_m_a", 32'(b0.y), 32'd0);
    x = 2'b00;
    tick();
    chk("hold_y_r_b", 32'(b1.y), 32'd1);
    chk("hold_y_m_b", 32'(b0.y), 32'd1);
    x = 2'b11;
    tick();
    chk("hold_y_r_c", 32'(b1.y), 32'd1);
    chk_both_st("hold", 2'd3, 16'd5);
    en = 1; x = 2'b00;
    tick();
    chk_both_st("reenter1", 2'd1, 16'd6);
    tick();
    chk_both_st("reenter2", 2'd2, 16'd7);
    chk("new_entry_y_m", 32'(b0.y), 32'd0);
    tick();
    chk_both_st("new_entry", 2'd0, 16'd8);
    chk("new_entry_y_r", 32'(b1.y), 32'd0);
    x = 2'b01;
    tick();
    x = 2'b10;
    tick();
    chk_both_st("to3", 2'd3, 16'd10);
    x = 2'b00;
    tick();
    chk_both_st("s3_pre_rst", 2'd1, 16'd11);
    chk("s3_pre_rst_y_r", 32'(b1.y), 32'd1);
    x = 2'b10;
    tick();
    chk_both_st("back_to3", 2'd3, 16'd12);
    x = 2'b00;
    tick();
    x = 2'b10;
    tick();
    tick();
    chk("pre_rst_y_r", 32'(b1.y), 32'd1);
    chk_both_st("pre_rst", 2'd3, 16'd14);
    rst_n = 0; cfg_we = 1; cfg_state = 2'd0; cfg_in = 2'b01; cfg_next = 2'd2; cfg_out = 1;
    tick();
    rst_n = 1; cfg_we = 0; en = 0;
    chk_both_st("mid_rst", 2'd0, 16'd0);
    chk("mid_rst_y_r", 32'(b1.y), 32'd0);
    x = 2'b01;
    #1;
    chk("mid_rst_discard_y_m", 32'(b0.y), 32'd0);
    en = 1;
    tick();
    chk_both_st("mid_rst_cleared", 2'd0, 16'd0);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      wr(2'd0, 2'(i), 2'd1, 1'b0);
      wr(2'd1, 2'(i), 2'd0, 1'b1);
    end
    en = 1;
    for (int k = 0; k < 65540; k++) begin
      x = 2'(k);
      tick();
    end
    chk_both_st("sat", 2'd0, 16'hFFFF);
    tick();
    chk_both_st("sat_more", 2'd1, 16'hFFFF);
    chk("sat_y_m", 32'(b0.y), 32'd1);
    chk("sat_y_r", 32'(b1.y), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_mealy_fsm.md
# prog_mealy_fsm

Table-driven, run-time programmable finite-state machine with parametrised state, input and output widths. The transition and output table lives in an internal register file that is loaded through a write port. The block runs as a Mealy machine (combinational output) or as a registered-output machine, selected by parameter. It is the general sequence-detector/controller block for lab designs that previously used hard-coded 4-state, 2-input-bit FSMs.

## Interface
Parameters:
- STATE_W, 2, state register width; number of states N = 2^STATE_W
- IN_W, 2, input symbol width
- OUT_W, 1, output width
- RESET_STATE, 0, state entered on reset; must be < N
- REG_OUT, 0, 0 = Mealy combinational output; 1 = registered output

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  advance enable; state is held when 0
- x  input  IN_W  input symbol
- y  output  OUT_W  machine output
- state_o  output  STATE_W  current state
- cfg_we  input  1  table write strobe
- cfg_state  input  STATE_W  table row: present state
- cfg_in  input  IN_W  table column: input symbol
- cfg_next  input  STATE_W  next state to store
- cfg_out  input  OUT_W  output value to store
- trans_cnt  output  16  count of enabled cycles where the state changed (saturating)

## Operation
- Table: 2^(STATE_W+IN_W) entries, each holding {next[STATE_W], out[OUT_W]}. Entries are indexed by {state, x}.
- Reset (rst_n=0 at a clk edge):
  - state <= RESET_STATE
  - every table entry <= {RESET_STATE, 0}
  - trans_cnt <= 0
  - registered y <= 0
  - reset has priority over cfg_we and en.
- Config write: when cfg_we=1 at an edge, entry {cfg_state, cfg_in} <= {cfg_next, cfg_out}. Only that entry changes.
- Advance: when en=1 at an edge, state <= entry[{state, x}].next.
- If the new state differs from the old state, trans_cnt increments. It saturates at 16'hFFFF.
- REG_OUT=0: y = entry[{state, x}].out, combinational from current state, current x and current table contents. y is independent of en.
- REG_OUT=1: on every en=1 edge, y <= entry[{state, x}].out, evaluated before the transition. y holds when en=0.
- state_o = state register, always.
- Simultaneous cfg_we and en in one cycle:
  - the transition and the registered y use the table contents from before the write;
  - the write becomes visible from the next cycle.
  - This holds even when the written index equals {state, x}.
- en=0: state, trans_cnt and registered y all hold. Config writes still proceed.
- x with unknown bits is not specified. The bench drives only known values.

## Timing
- Combinational Mealy path: x to y, through the table read mux, within the same cycle.
- State latency: 1 cycle from the en=1 edge.
- Table write latency: 1 cycle. A write at edge k affects y and next state from cycle k+1 onward.
- Reset mid-run: the first en=1 edge after rst_n returns high transitions from RESET_STATE using the reset table. The table must be reloaded after any reset.
- No handshake on cfg_*. One write is accepted per cycle, back-to-back writes included.

## Test plan
Table T4 used below (STATE_W=2, IN_W=2, OUT_W=1), listed as state: x→next/out:
- 0: 00→0/0, 01→1/0, 10→2/0, 11→0/0
- 1: 00→2/0, 01→0/0, 10→3/0, 11→1/0
- 2: 00→3/1, 01→0/0, 10→1/0, 11→2/0
- 3: 00→1/1, 01→0/0, 10→3/1, 11→0/0

Scenarios:
1. Reset, then en=1 with x=01 for 3 cycles, no table load → state_o stays 0, y=0, trans_cnt=0.
2. Load T4 (16 writes, REG_OUT=0), then x=01,10,00,00 with en=1 → state_o 0→1→3→1→2. y during each cycle is 0,0,1,0 (the third cycle is state 3 with x=00). trans_cnt=4.
3. REG_OUT=1, T4 loaded, same sequence → y after edges 1..4 = 0,0,1,0. y holds its value when en drops to 0 with x toggling.
4. In state 2 with x=00, en=1 and cfg_we writing entry {2,00}={0,0} in the same cycle → next state is 3 (old entry). Re-enter state 2 with x=00 → next state 0 and y=0.
5. Assert rst_n=0 for 1 cycle in state 3 with en=1 and cfg_we=1 → state_o=0, y=0, trans_cnt=0. The table is cleared and the write is discarded.
6. Load a 2-state table that toggles 0↔1 on every symbol, then run 65540 enabled cycles → trans_cnt=16'hFFFF (saturates) and state keeps toggling.
